// File: rtl/psum_drain.sv
// Drains partial sums from a show-ahead FIFO into a 2-entry skid buffer feeding a valid/ready sink.
// Define PSUM_RELU_EN to clamp negative words to zero as they enter the buffer.
module psum_drain #(
   parameter int sum_bw = 22,
   parameter int cnt_bw = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [cnt_bw-1:0] num_words,
   input  logic              fifo_empty,
   input  logic [sum_bw-1:0] fifo_out,
   output logic              rd,
   output logic [sum_bw-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [cnt_bw-1:0] drained_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [cnt_bw-1:0] CNT_ONE = cnt_bw'(1);

   logic [1:0]        state;
   logic [cnt_bw-1:0] target;
   logic [cnt_bw-1:0] issued;
   logic [1:0]        occ;
   logic [sum_bw-1:0] slot0;
   logic [sum_bw-1:0] slot1;
   logic [sum_bw-1:0] wr_word;
   logic              push;
   logic              pop;

`ifdef PSUM_RELU_EN
   assign wr_word = fifo_out[sum_bw-1] ? '0 : fifo_out;
`else
   assign wr_word = fifo_out;
`endif

   // Pop decision uses only registered occupancy, so out_ready never reaches rd.
   assign rd        = (state == DRAIN) & ~fifo_empty & (occ < 2'd2) & (issued < target);
   assign push      = rd;
   assign out_valid = (occ != 2'd0);
   assign out_data  = slot0;
   assign pop       = out_valid & out_ready;
   assign busy      = (state != IDLE);
   assign done      = (state == FLUSH) & (occ == 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         target <= '0;
         issued <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= DRAIN;
                  target <= num_words;
                  issued <= '0;
               end
            end
            DRAIN: begin
               if (push) issued <= issued + CNT_ONE;
               if (issued == target) state <= FLUSH;
            end
            FLUSH: begin
               if (occ == 2'd0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drained_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         drained_cnt <= '0;
      end else if (pop) begin
         drained_cnt <= drained_cnt + CNT_ONE;
      end
   end

   // slot0 is always the head; a push alongside a pop can only happen at occupancy 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ   <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= wr_word;
               else             slot1 <= wr_word;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               slot0 <= wr_word;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: a queue-based FIFO model feeds the DUT and a monitor checks every transfer.
module tb_psum_drain;

   localparam int SUM_BW = 22;
   localparam int CNT_BW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [CNT_BW-1:0] num_words;
   logic              fifo_empty;
   logic [SUM_BW-1:0] fifo_out;
   logic              rd;
   logic [SUM_BW-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic [CNT_BW-1:0] drained_cnt;

   int total = 0;
   int bad = 0;
   int pop_count = 0;
   int pop_base = 0;

   logic [SUM_BW-1:0] fifo_q[$];
   logic [SUM_BW-1:0] exp_q[$];
   logic              rd_s = 1'b0;
   logic              gate = 1'b0;
   logic              toggle_en = 1'b0;
   logic              ready_rand = 1'b0;
   logic              ready_force = 1'b1;
   logic              prev_stall = 1'b0;
   logic [SUM_BW-1:0] prev_data = '0;

   psum_drain #(.sum_bw(SUM_BW), .cnt_bw(CNT_BW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .fifo_empty(fifo_empty), .fifo_out(fifo_out), .rd(rd),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .drained_cnt(drained_cnt)
   );

   always #5 clk = ~clk;

   // Reference transform: negative words clamp to zero only in the ReLU build.
   function automatic logic [SUM_BW-1:0] ref_word(input logic [SUM_BW-1:0] w);
`ifdef PSUM_RELU_EN
      if ($signed(w) < 0) return '0;
`endif
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic refresh_fifo();
      fifo_empty = gate | (fifo_q.size() == 0);
      fifo_out   = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(SUM_BW'($urandom));
      refresh_fifo();
   endtask

   // FIFO model: pops on the edge after rd was seen high, then republishes its head.
   always @(posedge clk) begin
      if (rd_s && fifo_q.size() > 0) begin
         fifo_q.delete(0);
         pop_count++;
      end
      gate = toggle_en ? ~gate : 1'b0;
      #1;
      refresh_fifo();
   end

   always @(posedge clk) begin
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // Monitor: every accepted word must match the head of the expected queue.
   always @(negedge clk) begin
      rd_s = rd;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (rd) checkOutput("rd_while_empty", 32'(fifo_empty), 32'd0);
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_word: got 0x%0h, expected no transfer at %0t", out_data, $time);
            end else begin
               checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
               exp_q.delete(0);
            end
         end
         prev_stall = out_valid & ~out_ready;
         prev_data  = out_data;
      end
   end

   task automatic applyStimulus(input int n);
      @(posedge clk);
      #2;
      for (int i = 0; i < n && i < fifo_q.size(); i++) exp_q.push_back(ref_word(fifo_q[i]));
      pop_base  = pop_count;
      start     = 1'b1;
      num_words = CNT_BW'(n);
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (done) break;
         if (cycles >= 400) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
            break;
         end
      end
   endtask

   task automatic checkDrain(input int n);
      checkOutput("drained_cnt", 32'(drained_cnt), 32'(n));
      checkOutput("pop_count", 32'(pop_count - pop_base), 32'(n));
      checkOutput("exp_left", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("cnt_hold", 32'(drained_cnt), 32'(n));
      checkOutput("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int cyc;
      int n;
      int remaining;
      logic [SUM_BW-1:0] w;

      reset = 1'b1;
      start = 1'b0;
      num_words = '0;
      out_ready = 1'b1;
      refresh_fifo();
      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_rd", 32'(rd), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_drained", 32'(drained_cnt), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      $display("[TB] basic drain 1..4");
      for (int i = 1; i <= 4; i++) fifo_q.push_back(SUM_BW'(i));
      refresh_fifo();
      applyStimulus(4);
      waitDone(cyc);
      checkOutput("throughput_cycles", 32'(cyc), 32'd6);
      checkDrain(4);

      $display("[TB] latency from fifo_empty falling");
      applyStimulus(1);
      repeat (3) @(posedge clk);
      #2;
      w = SUM_BW'($urandom);
      exp_q.push_back(ref_word(w));
      fifo_q.push_back(w);
      refresh_fifo();
      @(negedge clk);
      checkOutput("lat_rd", 32'(rd), 32'd1);
      checkOutput("lat_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("lat_valid", 32'(out_valid), 32'd1);
      waitDone(cyc);
      checkDrain(1);

      $display("[TB] backpressure drain of 6");
      ready_force = 1'b0;
      @(posedge clk);
      #2;
      load_words(6);
      applyStimulus(6);
      repeat (10) @(negedge clk);
      checkOutput("stall_pops", 32'(pop_count - pop_base), 32'd2);
      checkOutput("stall_drained", 32'(drained_cnt), 32'd0);
      ready_force = 1'b1;
      waitDone(cyc);
      checkDrain(6);

      $display("[TB] zero-length drain");
      load_words(3);
      applyStimulus(0);
      @(negedge clk);
      checkOutput("zero_done_early", 32'(done), 32'd0);
      checkOutput("zero_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("zero_done", 32'(done), 32'd1);
      @(negedge clk);
      checkOutput("zero_done_pulse", 32'(done), 32'd0);
      checkOutput("zero_idle", 32'(busy), 32'd0);
      checkOutput("zero_pops", 32'(pop_count - pop_base), 32'd0);
      checkOutput("zero_drained", 32'(drained_cnt), 32'd0);
      @(posedge clk);
      #2;
      fifo_q.delete();
      refresh_fifo();

      $display("[TB] toggling fifo_empty, 8 words");
      toggle_en = 1'b1;
      load_words(8);
      applyStimulus(8);
      waitDone(cyc);
      checkDrain(8);
      toggle_en = 1'b0;

      $display("[TB] sign handling");
      fifo_q.push_back(22'h3FFFFF);
      fifo_q.push_back(22'h1FFFFF);
      refresh_fifo();
      applyStimulus(2);
      waitDone(cyc);
      checkDrain(2);

      $display("[TB] randomized drains");
      ready_rand = 1'b1;
      for (int k = 0; k < 6; k++) begin
         toggle_en = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 12);
         load_words(n + $urandom_range(0, 2));
         applyStimulus(n);
         waitDone(cyc);
         checkDrain(n);
      end
      toggle_en = 1'b0;
      @(posedge clk);
      #2;
      fifo_q.delete();
      refresh_fifo();

      $display("[TB] maximum target");
      load_words(31);
      applyStimulus(31);
      waitDone(cyc);
      checkDrain(31);
      ready_rand = 1'b0;
      ready_force = 1'b1;

      $display("[TB] reset mid-drain");
      @(posedge clk);
      #2;
      load_words(8);
      applyStimulus(8);
      for (int t = 0; t < 100; t++) begin
         @(posedge clk);
         #2;
         if (drained_cnt == CNT_BW'(3)) break;
      end
      checkOutput("pre_reset_drained", 32'(drained_cnt), 32'd3);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
      checkOutput("mid_rst_rd", 32'(rd), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      checkOutput("mid_rst_drained", 32'(drained_cnt), 32'd0);
      remaining = fifo_q.size();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("fifo_untouched", 32'(fifo_q.size()), 32'(remaining));
      reset = 1'b0;
      applyStimulus(remaining);
      waitDone(cyc);
      checkDrain(remaining);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got no completion, expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
